imem_program_loader: RTL
========================

// Module: imem_program_loader
// PURPOSE
// - Writer side of the instruction-memory interface: the core only reads 16-bit instructions at 8-bit PC addresses; this block fills that memory.
// - Receives a framed byte stream (valid/ready), assembles 16-bit words, writes them to sequential addresses and holds the core in reset until a load completes cleanly.
// - Frame layout: SYNC_BYTE, LEN (word count, 0 = 256), 2*LEN payload bytes (high byte first), then CHK (XOR of all payload bytes).
// PARAMETERS
// - ADDR_W         8       instruction address width (matches PC width)
// - DATA_W         16      instruction width; fixed at 2 bytes per word
// - SYNC_BYTE      8'hA5   frame start marker
// - BASE_ADDR      8'h00   address of the first word written
// - HOLD_AT_RESET  1       reset value of cpu_hold
// PORTS
// - clk          in   1       system clock; all state updates on the rising edge
// - reset        in   1       asynchronous, active-low; 0 resets the block
// - in_valid     in   1       in_data holds a valid byte
// - in_data      in   8       stream byte
// - in_ready     out  1       block can accept a byte; a byte transfers when in_valid && in_ready
// - abort        in   1       cancels the load in progress
// - imem_we      out  1       one-cycle instruction-memory write strobe
// - imem_addr    out  ADDR_W  write address
// - imem_wdata   out  DATA_W  write data
// - cpu_hold     out  1       holds the core in reset while 1
// - done         out  1       one-cycle pulse after a frame loads cleanly
// - error        out  1       sticky; cleared by the next SYNC_BYTE
// BEHAVIOUR
// - Reset values: state=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, done=0, error=0, cpu_hold=HOLD_AT_RESET, word index=0, checksum=0.
// - in_ready is decoded from state: 1 in IDLE, LEN, HI, LO and CHK; 0 in WRITE and DONE.
// - State transitions:
//   - IDLE:  non-sync bytes are discarded. On SYNC_BYTE: go to LEN, cpu_hold<=1, error<=0, checksum<=0.
//   - LEN:   store the byte as the word count (0 means 256), index<=0, go to HI.
//   - HI:    latch the high byte, XOR it into checksum, go to LO.
//   - LO:    latch the low byte, XOR it into checksum, go to WRITE.
//   - WRITE: lasts exactly one cycle. imem_we=1, imem_addr=BASE_ADDR+index (mod 2^ADDR_W), imem_wdata={hi,lo}; index++.
//            If this is the last word go to CHK, otherwise go to HI.
//   - CHK:   if the byte equals checksum go to DONE; otherwise error<=1, go to IDLE with cpu_hold held at 1.
//   - DONE:  lasts one cycle. done=1, cpu_hold<=0, go to IDLE.
// - Latency and throughput: the write strobe occurs the cycle after the LO byte is accepted; at most one word per 3 cycles.
// - Address wrap: BASE_ADDR+index wraps modulo 256; a LEN of 0 writes all 256 locations.
// - abort (checked before any stream byte, in any state other than IDLE):
//   - next state is IDLE, error<=1, cpu_hold stays 1.
//   - A byte presented in that cycle is accepted but ignored; no write is issued.
//   - In IDLE, abort has no effect.
// - A SYNC_BYTE value arriving mid-frame is treated as data; no resync occurs.
// - imem_we is never asserted outside WRITE. Partial frames never deassert cpu_hold.
// - Reset asserted mid-load: the async reset returns every state and output to its reset value in the same cycle; a write in progress is dropped.
// - A late-arriving byte is handled by the state that receives it; there is no timeout.
// STRUCTURE
// - Shared package / header: state encoding (IDLE, LEN, HI, LO, WRITE, CHK, DONE), LOADER_SYNC_BYTE, instruction width 16, PC width 8.
//   The core and the memory model use the same width constants.
// - Single module, one FSM plus an index counter and checksum register. No sub-module is needed.
// - The optional byte-to-word assembler may be split out as imem_word_packer if it is reused by a debug port.
// TESTING
// - 1. Load 2 words, base 0: stream A5 02 12 34 AB CD (12^34^AB^CD) -> writes 1234@00 and ABCD@01, done pulse, cpu_hold falls, error=0.
// - 2. Same frame with CHK wrong by one bit -> both writes occur, no done pulse, error=1, cpu_hold stays 1.
//      A following good frame clears error and releases cpu_hold.
// - 3. LEN=00, BASE_ADDR=8'hF0 -> 256 writes, addresses F0..FF then 00..EF; done after the last write.
// - 4. Bytes 00 FF 5A then A5 01 00 07 07 -> the leading bytes are dropped and a single write of 0007@00 occurs.
// - 5. Throttled stream: in_valid low for random gaps; with in_valid held high, in_ready must be low during each WRITE.
//      Data and addresses must match test 1 exactly.
// - 6. abort after the HI byte of word 1 -> no further writes, error=1, cpu_hold=1.
//      Reset (reset=0) asserted during WRITE -> imem_we=0 immediately and all outputs at reset values.

Source files
------------

// File: rtl/imem_program_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory program loader.
// The core and the memory model use the same width constants declared here.
`timescale 1ns/1ps
package imem_program_loader_pkg;

    // Instruction width and program-counter (address) width seen by the core.
    localparam int INSTR_W = 16;
    localparam int PC_W    = 8;

    // Byte that opens every frame.
    localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

    // The LEN field is one byte, so a frame holds 1..256 words.
    localparam int WORD_CNT_W = 9;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_HI    = 3'd2,
        ST_LO    = 3'd3,
        ST_WRITE = 3'd4,
        ST_CHK   = 3'd5,
        ST_DONE  = 3'd6
    } loader_state_e;

    // Convert the LEN byte to a word count: 0 encodes a full 256-word frame.
    function automatic logic [WORD_CNT_W-1:0] frame_len_words(input logic [7:0] len_byte);
        logic [WORD_CNT_W-1:0] cnt;
        if (len_byte == 8'h00) begin
            cnt = WORD_CNT_W'(256);
        end else begin
            cnt = {1'b0, len_byte};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte-stream handshake into the loader: a byte moves when in_valid && in_ready.
`timescale 1ns/1ps
interface imem_program_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    // Source of the byte stream (host / UART side).
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Consumer of the byte stream (the loader).
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader: parses SYNC/LEN/payload/CHK frames from a
// byte stream, writes 16-bit words to sequential addresses and keeps the core
// held in reset until a frame has loaded with a matching checksum.
`timescale 1ns/1ps
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int               ADDR_W        = PC_W,
    parameter int               DATA_W        = INSTR_W,
    parameter logic [7:0]       SYNC_BYTE     = LOADER_SYNC_BYTE,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter bit               HOLD_AT_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,      // asynchronous, active-low
    imem_program_loader_if.slave   stream,
    input  logic                   abort,
    output logic                   imem_we,
    output logic [ADDR_W-1:0]      imem_addr,
    output logic [DATA_W-1:0]      imem_wdata,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   error
);

    loader_state_e           state_q,      state_d;
    logic [WORD_CNT_W-1:0]   len_q,        len_d;
    logic [WORD_CNT_W-1:0]   index_q,      index_d;
    logic [7:0]              checksum_q,   checksum_d;
    logic [7:0]              hi_q,         hi_d;
    logic                    imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0]       imem_addr_q,  imem_addr_d;
    logic [DATA_W-1:0]       imem_wdata_q, imem_wdata_d;
    logic                    cpu_hold_q,   cpu_hold_d;
    logic                    done_q,       done_d;
    logic                    error_q,      error_d;

    logic                    in_ready;
    logic                    accept;
    logic [WORD_CNT_W-1:0]   index_inc;

    // Ready is a pure decode of state: the loader stalls the stream only in
    // the single-cycle WRITE and DONE states.
    assign in_ready        = (state_q != ST_WRITE) && (state_q != ST_DONE);
    assign stream.in_ready = in_ready;
    assign accept          = stream.in_valid && in_ready;
    assign index_inc       = index_q + WORD_CNT_W'(1);

    // Next-state and next-output computation for the frame parser.
    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        index_d      = index_q;
        checksum_d   = checksum_q;
        hi_d         = hi_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        cpu_hold_d   = cpu_hold_q;
        done_d       = 1'b0;
        error_d      = error_q;

        if ((state_q != ST_IDLE) && abort) begin
            // Abort wins over any byte presented this cycle; that byte is
            // consumed (in_ready may be high) but never written.
            state_d    = ST_IDLE;
            error_d    = 1'b1;
            cpu_hold_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept && (stream.in_data == SYNC_BYTE)) begin
                        state_d    = ST_LEN;
                        cpu_hold_d = 1'b1;
                        error_d    = 1'b0;
                        checksum_d = 8'h00;
                    end
                end

                ST_LEN: begin
                    if (accept) begin
                        len_d   = frame_len_words(stream.in_data);
                        index_d = '0;
                        state_d = ST_HI;
                    end
                end

                ST_HI: begin
                    if (accept) begin
                        hi_d       = stream.in_data;
                        checksum_d = checksum_q ^ stream.in_data;
                        state_d    = ST_LO;
                    end
                end

                ST_LO: begin
                    if (accept) begin
                        // The write strobe is registered, so it is set up here
                        // and is visible during the WRITE state cycle.
                        checksum_d   = checksum_q ^ stream.in_data;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = BASE_ADDR + ADDR_W'(index_q);
                        imem_wdata_d = DATA_W'({hi_q, stream.in_data});
                        state_d      = ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    index_d = index_inc;
                    if (index_inc == len_q) begin
                        state_d = ST_CHK;
                    end else begin
                        state_d = ST_HI;
                    end
                end

                ST_CHK: begin
                    if (accept) begin
                        if (stream.in_data == checksum_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            // Memory content is suspect: keep the core held.
                            error_d = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end
                end

                ST_DONE: begin
                    cpu_hold_d = 1'b0;
                    state_d    = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and registered outputs; reset drops any write that is in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            index_q      <= '0;
            checksum_q   <= 8'h00;
            hi_q         <= 8'h00;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= HOLD_AT_RESET;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            index_q      <= index_d;
            checksum_q   <= checksum_d;
            hi_q         <= hi_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_hold_q   <= cpu_hold_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule
